// File: rtl/led_pkg.sv
// Shared types and constants for the LED comet-trail PWM stage.
// Optional square-law brightness map is enabled with LED_TRAIL_GAMMA_EN.
package led_pkg;

   localparam int N_LEDS_DEF = 16;
   localparam int BW_DEF     = 4;
   localparam int MAX_B      = (1 << BW_DEF) - 1;

   typedef logic [BW_DEF-1:0] bright_t;

   // Saturating subtract: a vacated LED fades toward zero and never wraps.
   function automatic bright_t sat_sub(input bright_t a, input bright_t d);
      return (a > d) ? bright_t'(a - d) : '0;
   endfunction

endpackage

// File: rtl/trail_cell.sv
// One LED channel: brightness register, head/decay update, duty map, PWM compare.
// With LED_TRAIL_GAMMA_EN defined the duty is (bright*bright) >> BW instead of bright.
module trail_cell
   import led_pkg::*;
#(
   parameter int DECAY = 4
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    en_i,
   input  logic    m_tick_i,
   input  logic    pos_i,
   input  bright_t pwm_cnt_i,
   output logic    led_o
);

   localparam bright_t MAX_B_T = bright_t'(MAX_B);
   localparam bright_t DECAY_T = bright_t'(DECAY);

   bright_t bright_q, bright_d;
   bright_t duty;
   logic    led_q;

   // A head always wins over decay on the same tick.
   always_comb begin
      bright_d = bright_q;
      if (en_i) begin
         if (pos_i) begin
            bright_d = MAX_B_T;
         end else if (m_tick_i) begin
            bright_d = sat_sub(bright_q, DECAY_T);
         end
      end
   end

`ifdef LED_TRAIL_GAMMA_EN
   logic [2*BW_DEF-1:0] bright_sq;
   assign bright_sq = {{BW_DEF{1'b0}}, bright_q} * {{BW_DEF{1'b0}}, bright_q};
   assign duty      = bright_sq[2*BW_DEF-1:BW_DEF];
`else
   assign duty = bright_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bright_q <= '0;
         led_q    <= 1'b0;
      end else begin
         bright_q <= bright_d;
         led_q    <= (duty > pwm_cnt_i);
      end
   end

   assign led_o = led_q;

endmodule

// File: rtl/led_trail_pwm.sv
// Comet-tail LED renderer: per-LED fading brightness driven through a shared prescaled PWM.
// Build option LED_TRAIL_GAMMA_EN selects a square-law duty map inside each trail_cell.
module led_trail_pwm
   import led_pkg::*;
#(
   parameter int N_LEDS  = N_LEDS_DEF,
   parameter int BW      = BW_DEF,
   parameter int DECAY   = 4,
   parameter int PWM_DIV = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              m_tick,
   input  logic [N_LEDS-1:0] pos,
   output logic [N_LEDS-1:0] led
);

   // PWM_DIV of 1 still needs a one-bit prescaler that is permanently at its wrap value.
   localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

   logic [PW-1:0] pre_q, pre_d;
   logic [BW-1:0] pwm_q, pwm_d;
   logic          pre_wrap;

   assign pre_wrap = (pre_q == PW'(PWM_DIV - 1));

   always_comb begin
      pre_d = pre_wrap ? '0 : pre_q + PW'(1);
      pwm_d = pre_wrap ? pwm_q + BW'(1) : pwm_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q <= '0;
         pwm_q <= '0;
      end else begin
         pre_q <= pre_d;
         pwm_q <= pwm_d;
      end
   end

   // The cells use led_pkg::bright_t, so BW is expected to equal led_pkg::BW_DEF.
   for (genvar i = 0; i < N_LEDS; i++) begin : g_cell
      trail_cell #(
         .DECAY(DECAY)
      ) u_cell (
         .clk      (clk),
         .reset    (reset),
         .en_i     (en),
         .m_tick_i (m_tick),
         .pos_i    (pos[i]),
         .pwm_cnt_i(pwm_q),
         .led_o    (led[i])
      );
   end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: two instances (PWM_DIV 1 and 4) against a cycle-count reference model.
// Expected duties follow LED_TRAIL_GAMMA_EN when the bundle is built with it.
module tb_led_trail_pwm;

   logic        clk    = 1'b0;
   logic        reset  = 1'b1;
   logic        en     = 1'b0;
   logic        m_tick = 1'b0;
   logic [15:0] pos    = '0;
   logic [15:0] led_a, led_b;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   led_trail_pwm #(.N_LEDS(16), .BW(4), .DECAY(4), .PWM_DIV(1)) dut_a (
      .clk(clk), .reset(reset), .en(en), .m_tick(m_tick), .pos(pos), .led(led_a)
   );

   led_trail_pwm #(.N_LEDS(16), .BW(4), .DECAY(4), .PWM_DIV(4)) dut_b (
      .clk(clk), .reset(reset), .en(en), .m_tick(m_tick), .pos(pos), .led(led_b)
   );

   function automatic int duty_of(input int b);
`ifdef LED_TRAIL_GAMMA_EN
      return (b * b) >> 4;
`else
      return b;
`endif
   endfunction

   // Reference: brightness per LED as integers; PWM phase derived from clocks since reset.
   int          m_br[16];
   int          cyc;
   logic [15:0] m_led_a, m_led_b;
   bit          chk_on = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) m_br[i] = 0;
         cyc     = 0;
         m_led_a = '0;
         m_led_b = '0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            m_led_a[i] = (duty_of(m_br[i]) > (cyc % 16));
            m_led_b[i] = (duty_of(m_br[i]) > ((cyc / 4) % 16));
         end
         for (int i = 0; i < 16; i++) begin
            if (en) begin
               if (pos[i]) m_br[i] = 15;
               else if (m_tick) m_br[i] = (m_br[i] > 4) ? m_br[i] - 4 : 0;
            end
         end
         cyc++;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         n_cmp++;
         assert (led_a === m_led_a) else begin
            n_fail++;
            $error("FAIL led_a cyc=%0d observed=%h expected=%h", cyc, led_a, m_led_a);
         end
         n_cmp++;
         assert (led_b === m_led_b) else begin
            n_fail++;
            $error("FAIL led_b cyc=%0d observed=%h expected=%h", cyc, led_b, m_led_b);
         end
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   int cnt_a[16];
   int cnt_b[16];

   task automatic count_win(input int n);
      for (int i = 0; i < 16; i++) begin
         cnt_a[i] = 0;
         cnt_b[i] = 0;
      end
      repeat (n) begin
         @(negedge clk);
         for (int i = 0; i < 16; i++) begin
            cnt_a[i] += int'(led_a[i]);
            cnt_b[i] += int'(led_b[i]);
         end
      end
   endtask

   task automatic tick_once();
      m_tick = 1'b1;
      step(1);
      m_tick = 1'b0;
   endtask

   initial begin
      int exp_tail[4];
      int lit;
      exp_tail[0] = 11; exp_tail[1] = 7; exp_tail[2] = 3; exp_tail[3] = 0;

      // reset hold
      reset = 1'b1; en = 1'b1; pos = '0;
      step(3);
      reset  = 1'b0;
      chk_on = 1'b1;
      count_win(64);
      lit = 0;
      for (int i = 0; i < 16; i++) lit += cnt_a[i] + cnt_b[i];
      check("reset_hold_dark", lit, 0);

      // single head at full brightness
      pos = 16'h0001;
      step(2);
      count_win(64);
      check("head_a_bit0", cnt_a[0], 4 * duty_of(15));
      check("head_b_bit0", cnt_b[0], 4 * duty_of(15));
      lit = 0;
      for (int i = 1; i < 16; i++) lit += cnt_a[i] + cnt_b[i];
      check("head_others_dark", lit, 0);

      // comet tail: bit 0 fades while bit 1 becomes the head
      pos = 16'h0002;
      for (int k = 0; k < 4; k++) begin
         tick_once();
         step(1);
         count_win(64);
         check($sformatf("tail_a_%0d", k), cnt_a[0], 4 * duty_of(exp_tail[k]));
         check($sformatf("tail_b_%0d", k), cnt_b[0], 4 * duty_of(exp_tail[k]));
         check($sformatf("tail_head_%0d", k), cnt_a[1], 4 * duty_of(15));
      end

      // freeze: bit 0 at 7, then en low with ticks and a head on bit 0
      pos = 16'h0001;
      step(1);
      pos = 16'h0002;
      tick_once();
      tick_once();
      en  = 1'b0;
      pos = 16'h0001;
      m_tick = 1'b1;
      step(5);
      m_tick = 1'b0;
      step(1);
      count_win(64);
      check("freeze_a_bit0", cnt_a[0], 4 * duty_of(7));
      check("freeze_b_bit0", cnt_b[0], 4 * duty_of(7));
      check("freeze_a_bit1", cnt_a[1], 4 * duty_of(15));

      // back-to-back ticks decay once per cycle
      en  = 1'b1;
      pos = 16'h0000;
      m_tick = 1'b1;
      step(2);
      m_tick = 1'b0;
      step(1);
      count_win(64);
      check("b2b_a_bit1", cnt_a[1], 4 * duty_of(7));
      check("b2b_a_bit0", cnt_a[0], 4 * duty_of(0));

      // two heads, then asynchronous reset between clock edges
      pos = 16'h8001;
      step(2);
      count_win(64);
      check("multi_a_bit0", cnt_a[0], 4 * duty_of(15));
      check("multi_a_bit15", cnt_a[15], 4 * duty_of(15));
      check("multi_b_bit15", cnt_b[15], 4 * duty_of(15));
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_rst_led_a", int'(led_a), 0);
      check("async_rst_led_b", int'(led_b), 0);
      step(1);
      reset = 1'b0;
      step(40);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         case ($urandom_range(0, 3))
            0:       pos = 16'h0000;
            1, 2:    pos = 16'h0001 << $urandom_range(0, 15);
            default: pos = 16'($urandom);
         endcase
         en     = ($urandom_range(0, 7) != 0);
         m_tick = ($urandom_range(0, 3) == 0);
         step(1);
      end
      m_tick = 1'b0;
      step(2);
      chk_on = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
